// File: rtl/rob_param_if.sv
// rob_param_if: issue, CDB and commit signals of the reorder buffer.
// The slave modport is the ROB; the master is whoever drives issue/CDB and consumes commits.
interface rob_param_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64,
   parameter int REG_W  = 5
);
   localparam int IDX_W = $clog2(DEPTH);
   logic              alloc_valid;
   logic [REG_W-1:0]  alloc_dest;
   logic              alloc_nodest;
   logic              alloc_is_store;
   logic              alloc_ready;
   logic [IDX_W-1:0]  alloc_id;
   logic              cdb_valid;
   logic [IDX_W-1:0]  cdb_slot;
   logic [DATA_W-1:0] cdb_data;
   logic [DATA_W-1:0] cdb_addr;
   logic              cdb_mispredict;
   logic              commit_valid;
   logic              commit_ready;
   logic [IDX_W-1:0]  commit_slot;
   logic [REG_W-1:0]  commit_dest;
   logic [DATA_W-1:0] commit_data;
   logic [DATA_W-1:0] commit_addr;
   logic              commit_wr;
   logic              commit_store;
   logic              flush;
   logic [IDX_W:0]    count;
   logic              empty;
   logic              full;
   modport master (
      output alloc_valid, alloc_dest, alloc_nodest, alloc_is_store,
             cdb_valid, cdb_slot, cdb_data, cdb_addr, cdb_mispredict, commit_ready,
      input  alloc_ready, alloc_id, commit_valid, commit_slot, commit_dest, commit_data,
             commit_addr, commit_wr, commit_store, flush, count, empty, full
   );
   modport slave (
      input  alloc_valid, alloc_dest, alloc_nodest, alloc_is_store,
             cdb_valid, cdb_slot, cdb_data, cdb_addr, cdb_mispredict, commit_ready,
      output alloc_ready, alloc_id, commit_valid, commit_slot, commit_dest, commit_data,
             commit_addr, commit_wr, commit_store, flush, count, empty, full
   );
endinterface

// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer; in-order allocate/retire, out-of-order CDB capture,
// pipeline flush when a mispredicted branch retires.
module rob_param #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64,
   parameter int REG_W  = 5
) (
   input logic        clk,
   input logic        rst,
   rob_param_if.slave io
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d, mis_q, mis_d, st_q, st_d, nd_q, nd_d;
   logic [REG_W-1:0]  dest_q [DEPTH];
   logic [REG_W-1:0]  dest_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [DATA_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] addr_d [DEPTH];
   logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              alloc_fire, fire;
   assign io.full         = count_q == CNT_W'(DEPTH);
   assign io.empty        = count_q == '0;
   assign io.count        = count_q;
   assign io.alloc_ready  = ~io.full;
   assign io.alloc_id     = tail_q;
   assign io.commit_valid = busy_q[head_q] & done_q[head_q];
   assign io.commit_slot  = head_q;
   assign io.commit_dest  = dest_q[head_q];
   assign io.commit_data  = data_q[head_q];
   assign io.commit_addr  = addr_q[head_q];
   assign fire            = io.commit_valid & io.commit_ready;
   assign alloc_fire      = io.alloc_valid & ~io.full;
   assign io.commit_wr    = fire & ~nd_q[head_q] & ~st_q[head_q];
   assign io.commit_store = fire & st_q[head_q];
   assign io.flush        = fire & mis_q[head_q];
   always_comb begin
      busy_d  = busy_q;
      done_d  = done_q;
      mis_d   = mis_q;
      st_d    = st_q;
      nd_d    = nd_q;
      dest_d  = dest_q;
      data_d  = data_q;
      addr_d  = addr_q;
      head_d  = head_q + IDX_W'(fire);
      tail_d  = tail_q + IDX_W'(alloc_fire);
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(fire);
      if (alloc_fire) begin
         busy_d[tail_q] = 1'b1;
         done_d[tail_q] = 1'b0;
         mis_d[tail_q]  = 1'b0;
         st_d[tail_q]   = io.alloc_is_store;
         nd_d[tail_q]   = io.alloc_nodest;
         dest_d[tail_q] = io.alloc_dest;
      end
      if (io.cdb_valid && busy_q[io.cdb_slot]) begin
         data_d[io.cdb_slot] = io.cdb_data;
         done_d[io.cdb_slot] = 1'b1;
         mis_d[io.cdb_slot]  = io.cdb_mispredict;
         addr_d[io.cdb_slot] = st_q[io.cdb_slot] ? io.cdb_addr : addr_q[io.cdb_slot];
      end
      if (fire) busy_d[head_q] = 1'b0;
      // flush wins over any same-cycle allocation or capture
      if (io.flush) begin
         busy_d  = '0;
         done_d  = '0;
         mis_d   = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '0;
         done_q  <= '0;
         mis_q   <= '0;
         st_q    <= '0;
         nd_q    <= '0;
         dest_q  <= '{default: '0};
         data_q  <= '{default: '0};
         addr_q  <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         mis_q   <= mis_d;
         st_q    <= st_d;
         nd_q    <= nd_d;
         dest_q  <= dest_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed vectors for the 4-entry/64-bit ROB and an 8-entry/32-bit instance.
module tb_rob_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   rob_param_if #(.DEPTH(4), .DATA_W(64), .REG_W(5)) a ();
   rob_param_if #(.DEPTH(8), .DATA_W(32), .REG_W(5)) b ();
   rob_param #(.DEPTH(4), .DATA_W(64), .REG_W(5)) dut_a (.clk(clk), .rst(rst), .io(a));
   rob_param #(.DEPTH(8), .DATA_W(32), .REG_W(5)) dut_b (.clk(clk), .rst(rst), .io(b));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask
   task automatic alloc_a(input logic [4:0] dest, input logic nodest, input logic st);
      a.alloc_valid = 1'b1; a.alloc_dest = dest; a.alloc_nodest = nodest; a.alloc_is_store = st;
      tick();
      a.alloc_valid = 1'b0;
   endtask
   task automatic cdb_a(input logic [1:0] slot, input logic [63:0] data, input logic [63:0] addr,
                        input logic mis);
      a.cdb_valid = 1'b1; a.cdb_slot = slot; a.cdb_data = data; a.cdb_addr = addr;
      a.cdb_mispredict = mis;
      tick();
      a.cdb_valid = 1'b0; a.cdb_mispredict = 1'b0;
   endtask
   task automatic alloc_b(input logic [4:0] dest);
      b.alloc_valid = 1'b1; b.alloc_dest = dest; b.alloc_nodest = 1'b0; b.alloc_is_store = 1'b0;
      tick();
      b.alloc_valid = 1'b0;
   endtask
   task automatic cdb_b(input logic [2:0] slot, input logic [31:0] data);
      b.cdb_valid = 1'b1; b.cdb_slot = slot; b.cdb_data = data; b.cdb_addr = '0;
      b.cdb_mispredict = 1'b0;
      tick();
      b.cdb_valid = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      logic [1:0] prev;
      a.alloc_valid = 0; a.alloc_dest = 0; a.alloc_nodest = 0; a.alloc_is_store = 0;
      a.cdb_valid = 0; a.cdb_slot = 0; a.cdb_data = 0; a.cdb_addr = 0; a.cdb_mispredict = 0;
      a.commit_ready = 1;
      b.alloc_valid = 0; b.alloc_dest = 0; b.alloc_nodest = 0; b.alloc_is_store = 0;
      b.cdb_valid = 0; b.cdb_slot = 0; b.cdb_data = 0; b.cdb_addr = 0; b.cdb_mispredict = 0;
      b.commit_ready = 1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_count", a.count, 0);
      chk("rst_empty", a.empty, 1);
      chk("rst_full", a.full, 0);
      chk("rst_ready", a.alloc_ready, 1);
      chk("rst_cvalid", a.commit_valid, 0);
      chk("rst_flush", a.flush, 0);
      chk("rst_cdata", a.commit_data, 0);
      // asynchronous reset with three entries outstanding
      alloc_a(5'd1, 0, 0);
      alloc_a(5'd2, 0, 0);
      alloc_a(5'd3, 0, 0);
      chk("mid_count3", a.count, 3);
      rst = 1'b1;
      #1;
      chk("mid_count", a.count, 0);
      chk("mid_empty", a.empty, 1);
      chk("mid_cvalid", a.commit_valid, 0);
      chk("mid_ready", a.alloc_ready, 1);
      rst = 1'b0;
      chk("mid_id", a.alloc_id, 0);
      alloc_a(5'd7, 0, 0);
      chk("mid_count1", a.count, 1);
      // in-order retire of out-of-order results
      do_reset();
      alloc_a(5'd1, 0, 0);
      alloc_a(5'd2, 0, 0);
      chk("ino_id2", a.alloc_id, 2);
      alloc_a(5'd3, 0, 0);
      cdb_a(2'd2, 64'h22, 0, 0);
      chk("ino_cv_early", a.commit_valid, 0);
      a.cdb_valid = 1; a.cdb_slot = 2'd0; a.cdb_data = 64'h11;
      #1;
      chk("ino_cv_same", a.commit_valid, 0);
      tick();
      a.cdb_valid = 0;
      chk("ino0_cv", a.commit_valid, 1);
      chk("ino0_slot", a.commit_slot, 0);
      chk("ino0_dest", a.commit_dest, 1);
      chk("ino0_data", a.commit_data, 64'h11);
      chk("ino0_wr", a.commit_wr, 1);
      cdb_a(2'd1, 64'h33, 0, 0);
      chk("ino1_slot", a.commit_slot, 1);
      chk("ino1_dest", a.commit_dest, 2);
      chk("ino1_data", a.commit_data, 64'h33);
      chk("ino1_wr", a.commit_wr, 1);
      tick();
      chk("ino2_slot", a.commit_slot, 2);
      chk("ino2_dest", a.commit_dest, 3);
      chk("ino2_data", a.commit_data, 64'h22);
      chk("ino2_wr", a.commit_wr, 1);
      tick();
      chk("ino_empty", a.empty, 1);
      chk("ino_cv_end", a.commit_valid, 0);
      // full, ignored request, wrap
      do_reset();
      for (int i = 0; i < 4; i++) begin
         chk("full_id", a.alloc_id, i);
         alloc_a(5'(i + 8), 0, 0);
      end
      chk("full_full", a.full, 1);
      chk("full_ready", a.alloc_ready, 0);
      chk("full_count", a.count, 4);
      alloc_a(5'd20, 0, 0);
      chk("full_ignored", a.count, 4);
      cdb_a(2'd0, 64'h1, 0, 0);
      tick();
      chk("wrap_count", a.count, 3);
      chk("wrap_full", a.full, 0);
      chk("wrap_id", a.alloc_id, 0);
      alloc_a(5'd21, 0, 0);
      chk("wrap_count4", a.count, 4);
      do_reset();
      prev = 0;
      for (int i = 0; i < 12; i++) begin
         a.alloc_valid = 1; a.alloc_dest = 5'(i);
         a.cdb_valid = (i > 0); a.cdb_slot = prev; a.cdb_data = 64'(i);
         prev = a.alloc_id;
         tick();
         chk("loop_range", a.count <= 4, 1);
      end
      a.alloc_valid = 0; a.cdb_valid = 0;
      // store held by commit_ready
      do_reset();
      a.commit_ready = 0;
      alloc_a(5'd0, 1, 1);
      cdb_a(2'd0, 64'h5, 64'h40, 0);
      for (int i = 0; i < 3; i++) begin
         chk("st_cv", a.commit_valid, 1);
         chk("st_hold", a.commit_store, 0);
         chk("st_hold_addr", a.commit_addr, 64'h40);
         chk("st_hold_data", a.commit_data, 64'h5);
         tick();
      end
      a.commit_ready = 1;
      #1;
      chk("st_store", a.commit_store, 1);
      chk("st_addr", a.commit_addr, 64'h40);
      chk("st_data", a.commit_data, 64'h5);
      chk("st_wr", a.commit_wr, 0);
      tick();
      chk("st_empty", a.empty, 1);
      // mispredicted branch retire
      do_reset();
      alloc_a(5'd0, 1, 0);
      alloc_a(5'd4, 0, 0);
      alloc_a(5'd5, 0, 0);
      cdb_a(2'd1, 64'h4, 0, 0);
      cdb_a(2'd2, 64'h5, 0, 0);
      cdb_a(2'd0, 64'h0, 0, 1);
      chk("mp_flush", a.flush, 1);
      chk("mp_wr", a.commit_wr, 0);
      a.alloc_valid = 1; a.alloc_dest = 5'd9;
      tick();
      a.alloc_valid = 0;
      chk("mp_count", a.count, 0);
      chk("mp_empty", a.empty, 1);
      chk("mp_flush_off", a.flush, 0);
      chk("mp_cv", a.commit_valid, 0);
      chk("mp_id", a.alloc_id, 0);
      tick();
      chk("mp_cv2", a.commit_valid, 0);
      // DEPTH=8 / DATA_W=32 instance
      do_reset();
      alloc_b(5'd1);
      cdb_b(3'd0, 32'hAB);
      chk("b_cdata", b.commit_data, 32'hAB);
      tick();
      chk("b_empty", b.empty, 1);
      cdb_b(3'd1, 32'hDEAD);
      chk("b_stray_cv", b.commit_valid, 0);
      for (int i = 0; i < 8; i++) begin
         chk("b_id", b.alloc_id, (i + 1) % 8);
         alloc_b(5'(i));
      end
      chk("b_full", b.full, 1);
      chk("b_count", b.count, 8);
      chk("b_ready", b.alloc_ready, 0);
      chk("b_stray_cv2", b.commit_valid, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer for the Tomasulo core; supersedes the fixed 4-entry ROB with 2-bit slots.
- Sits between issue, the CDB and the register file/memory.
- Allocates in-order entries at issue and captures out-of-order CDB results by slot.
- Retires one entry per cycle in program order; raises a pipeline-wide flush when a mispredicted branch retires.

Parameters:
- DEPTH, 4, entry count; power of two, at least 2.
- DATA_W, 64, result/address width.
- REG_W, 5, architectural register index width.
- IDX_W, $clog2(DEPTH), slot id width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  issue requests an entry this cycle.
- alloc_dest  in  REG_W  destination register.
- alloc_nodest  in  1  no register writeback (store, beq).
- alloc_is_store  in  1  entry is a store.
- alloc_ready  out  1  entry available (= ~full).
- alloc_id  out  IDX_W  slot granted to the current request (= tail).
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_slot  in  IDX_W  ROB slot of the broadcast.
- cdb_data  in  DATA_W  result (store: store value).
- cdb_addr  in  DATA_W  store effective address; ignored for non-stores.
- cdb_mispredict  in  1  branch resolved as mispredicted.
- commit_valid  out  1  head entry complete.
- commit_ready  in  1  consumer accepts the commit (memory may stall stores).
- commit_slot  out  IDX_W  head slot, so the regfile can clear matching tags.
- commit_dest  out  REG_W  head destination.
- commit_data  out  DATA_W  head result/store value.
- commit_addr  out  DATA_W  head store address.
- commit_wr  out  1  register write: commit fire & ~nodest & ~store.
- commit_store  out  1  store retire: commit fire & store.
- flush  out  1  mispredicted branch retiring this cycle.
- count  out  IDX_W+1  occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async, any time, including mid-operation):
  - head = tail = count = 0.
  - All busy/done/mispredict bits cleared.
  - All outputs 0 except alloc_ready = 1 and empty = 1.
  - Entry data contents are don't-care.
- Entry fields: busy, done, mispredict, is_store, nodest, dest, data, addr.
- Allocate: on alloc_valid & ~full at the clock edge:
  - entry[tail] gets busy=1, done=0, mispredict=0 plus the request fields.
  - tail = tail+1 mod DEPTH.
  - alloc_id is combinational from tail; valid in the same cycle.
  - alloc_valid while full: ignored, no state change.
- full uses the registered count. No allocation into a slot freed by a same-cycle commit; one bubble is accepted.
- Capture: on cdb_valid with entry[cdb_slot].busy set:
  - data <= cdb_data, done <= 1, mispredict <= cdb_mispredict.
  - addr <= cdb_addr when is_store.
  - Broadcast to a non-busy slot is ignored.
  - Repeated broadcast to a done slot overwrites (last write wins).
- Commit path:
  - commit_valid = busy[head] & done[head], from registers only.
  - A CDB write to head is committable in the next cycle, never the same cycle.
  - Fire = commit_valid & commit_ready. On fire: busy[head] cleared, head = head+1 mod DEPTH.
  - commit_ready low holds every commit_* output stable.
- Flush:
  - flush = fire & mispredict[head], combinational.
  - At that edge: all entries cleared, head = tail = count = 0.
  - A same-cycle allocation and CDB write are discarded.
  - The retiring branch itself is counted as committed.
- count next = count + alloc_fire - commit_fire. With no flush, a simultaneous allocate and commit leaves count unchanged.
- Pointer wrap: modulo DEPTH, no skipped slots. full and empty come from count, never from pointer compare.
- Simultaneous CDB write and allocate to the same slot cannot occur: a slot being allocated is not busy.

Test Plan:
- Reset mid-stream with 3 entries held → same cycle: count=0, empty=1, commit_valid=0, alloc_ready=1; next allocate gets alloc_id=0.
- In-order retire: allocate r1, r2, r3 (DEPTH=4); CDB writes slot2=0x22, then slot0=0x11, then slot1=0x33 →
  - commits in order slot0/r1/0x11, slot1/r2/0x33, slot2/r3/0x22;
  - commit_wr=1 each; commit 0 one cycle after its CDB write.
- Full and wrap: allocate 4 → full=1, alloc_ready=0, 5th request ignored.
  - Complete and commit slot0, then allocate → alloc_id=0, tail wrapped.
  - 12 allocate/commit cycles keep count within 0..4.
- Store handshake: allocate a store; CDB data=0x5 addr=0x40; hold commit_ready=0 for 3 cycles →
  - commit_store=0 and outputs stable;
  - on commit_ready=1: commit_store=1, commit_addr=0x40, commit_data=0x5, commit_wr=0.
- Mispredict flush: allocate beq (nodest), r4, r5; CDB results for r4, r5, then beq with mispredict=1 →
  - flush=1 on the beq commit; next cycle count=0, empty=1;
  - r4/r5 never commit; an allocation in the flush cycle is dropped.
- Parameter sweep: DEPTH=8, DATA_W=32 → 8 allocations before full; alloc_id spans 0..7.
  - Stray CDB write to a freed slot produces no commit.
